// File: rtl/ov5640_regs_pkg.sv
// Address map, read-timeout code and read FSM states shared by the HPS
// register write block and the readback slave.
package ov5640_regs_pkg;

  localparam logic [15:0] ADDR_REG_FIRST = 16'h0000;
  localparam logic [15:0] ADDR_REG_LAST  = 16'h000F;
  localparam logic [15:0] ADDR_STATUS    = 16'hFFFE;
  localparam logic [15:0] ADDR_RSVD      = 16'hFFFF;

  localparam logic [31:0] RD_TMO_CODE    = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAM_ARB  = 2'd1,
    ST_CAM_WAIT = 2'd2,
    ST_RESP     = 2'd3
  } rd_state_e;

  // Mirrored registers and the status word are answered locally; every other
  // address, including ADDR_RSVD, is forwarded to the camera.
  function automatic logic is_local_addr(input logic [15:0] addr);
    return (addr <= ADDR_REG_LAST) || (addr == ADDR_STATUS);
  endfunction

endpackage

// File: rtl/rd_timeout_cnt.sv
// Camera read watchdog: counts enabled cycles from a clear and flags the
// last permitted cycle.
module rd_timeout_cnt #(
  parameter int unsigned LIMIT = 2_000_000,
  parameter int unsigned W     = 21
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q, count_d;

  assign expire_o = en_i & (count_q == LAST);

  // Next count: clear wins, otherwise advance while enabled and saturate at LAST.
  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (en_i && (count_q != LAST))
      count_d = count_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/hps_readback_ov5640.sv
// Avalon-MM read slave on the h2f bridge: mirrored control registers and a
// status word are answered after one wait cycle, all other addresses become a
// single SCCB register read on the OV5640 engine.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | no transaction; decode a new read
// ST_CAM_ARB  | camera read pending until the engine is idle and no write is queued
// ST_CAM_WAIT | request issued, waiting for rd_valid or the watchdog
// ST_RESP     | readdata valid, waitrequest low for exactly one cycle
module hps_readback_ov5640
  import ov5640_regs_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
  parameter int unsigned TMO_W       = 21
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         avl_chipselect,
  input  logic         avl_read,
  input  logic [15:0]  avl_address,
  output logic [31:0]  avl_readdata,
  output logic         avl_waitrequest,
  input  logic [511:0] regs_in,
  input  logic         fb_enable,
  input  logic         cam_wr_busy,
  input  logic         ready_ov5640,
  output logic         rd_req_ov5640,
  output logic [15:0]  rd_addr_ov5640,
  input  logic         rd_valid_ov5640,
  input  logic [7:0]   rd_data_ov5640
);

  rd_state_e   state_q, state_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rd_req_q, rd_req_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic        rsp_ok_q;
  logic        abort_q, abort_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [15:0] cam_rd_cnt_q, cam_rd_cnt_d;
  logic        tmo_clr, tmo_en, tmo_expire;
  logic        rq, discard;
  logic [31:0] local_word, status_word;

  assign rq              = avl_chipselect & avl_read;
  assign avl_waitrequest = rq & ~rsp_ok_q;
  assign avl_readdata    = readdata_q;
  assign rd_req_ov5640   = rd_req_q;
  assign rd_addr_ov5640  = rd_addr_q;

  assign local_word  = regs_in[{avl_address[3:0], 5'd0} +: 32];
  assign status_word = {tmo_cnt_q, cam_rd_cnt_q, 5'b0, cam_wr_busy, ready_ov5640, fb_enable};

  // A master that let go of the read during CAM_WAIT no longer wants the result.
  assign discard = abort_q | ~rq;

  rd_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC),
    .W     (TMO_W)
  ) u_tmo (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  // Next-state, response data, camera request and counter updates.
  always_comb begin
    state_d      = state_q;
    readdata_d   = readdata_q;
    rd_req_d     = 1'b0;
    rd_addr_d    = rd_addr_q;
    abort_d      = abort_q;
    tmo_cnt_d    = tmo_cnt_q;
    cam_rd_cnt_d = cam_rd_cnt_q;
    tmo_clr      = 1'b0;
    tmo_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (rq) begin
          if (is_local_addr(avl_address)) begin
            readdata_d = (avl_address == ADDR_STATUS) ? status_word : local_word;
            state_d    = ST_RESP;
          end else begin
            rd_addr_d = avl_address;
            state_d   = ST_CAM_ARB;
          end
        end
      end
      ST_CAM_ARB: begin
        if (!rq) begin
          state_d = ST_IDLE;
        end else if (ready_ov5640 && !cam_wr_busy) begin
          rd_req_d = 1'b1;
          tmo_clr  = 1'b1;
          state_d  = ST_CAM_WAIT;
        end
      end
      ST_CAM_WAIT: begin
        tmo_en = 1'b1;
        if (!rq) abort_d = 1'b1;
        if (rd_valid_ov5640) begin
          cam_rd_cnt_d = cam_rd_cnt_q + 1'b1;
          if (!discard) readdata_d = {24'h0, rd_data_ov5640};
          state_d = discard ? ST_IDLE : ST_RESP;
        end else if (tmo_expire) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (!discard) readdata_d = RD_TMO_CODE;
          state_d = discard ? ST_IDLE : ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      readdata_q   <= '0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      rsp_ok_q     <= 1'b0;
      abort_q      <= 1'b0;
      tmo_cnt_q    <= '0;
      cam_rd_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      readdata_q   <= readdata_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      rsp_ok_q     <= (state_d == ST_RESP);
      abort_q      <= abort_d;
      tmo_cnt_q    <= tmo_cnt_d;
      cam_rd_cnt_q <= cam_rd_cnt_d;
    end
  end

endmodule
